// File: rtl/sdram_pkg.sv
// Shared SDRAM definitions: command encodings, scheduler state type and
// small elaboration-time helpers for cycle counts and counter widths.
package sdram_pkg;

   localparam logic [3:0] CMD_NOP = 4'b0111;
   localparam logic [3:0] CMD_PRE = 4'b0010;
   localparam logic [3:0] CMD_AR  = 4'b0001;
   localparam logic [3:0] CMD_ACT = 4'b0011;
   localparam logic [3:0] CMD_RD  = 4'b0101;
   localparam logic [3:0] CMD_WR  = 4'b0100;
   localparam logic [3:0] CMD_MRS = 4'b0000;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PRE,
      ST_TRP,
      ST_AR,
      ST_TRFC,
      ST_END
   } ar_state_t;

   // Rounds up so that a timing parameter is never violated.
   function automatic int ns_to_cyc(input int t_ns, input int clk_mhz);
      return (t_ns * clk_mhz + 999) / 1000;
   endfunction

   function automatic int ns_to_cyc_min1(input int t_ns, input int clk_mhz);
      int c;
      c = ns_to_cyc(t_ns, clk_mhz);
      return (c < 1) ? 1 : c;
   endfunction

   // Bits needed to hold values 0..terminal, never less than one.
   function automatic int cnt_w(input int terminal);
      return (terminal < 1) ? 1 : $clog2(terminal + 1);
   endfunction

endpackage

// File: rtl/sdram_refi_timer.sv
// Free-running refresh interval timer: counts while enabled, held at zero
// otherwise, and flags the last cycle of every interval.
module sdram_refi_timer
   import sdram_pkg::*;
#(
   parameter int T_REFI_CYC = 780
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   output logic tick
);

   localparam int CNT_W = cnt_w(T_REFI_CYC - 1);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(T_REFI_CYC - 1);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt <= '0;
      else if (!en || cnt == LAST)
         cnt <= '0;
      else
         cnt <= cnt + 1'b1;
   end

   assign tick = en && (cnt == LAST);

endmodule

// File: rtl/sdram_aref_sched.sv
// Auto-refresh scheduler: accumulates owed refreshes as debt and, on grant,
// issues precharge-all followed by a burst of AUTO REFRESH commands.
module sdram_aref_sched
   import sdram_pkg::*;
#(
   parameter int T_REFI_CYC   = 780,
   parameter int T_RP_CYC     = 2,
   parameter int T_RFC_CYC    = 7,
   parameter int AR_BURST_MAX = 2,
   parameter int MAX_DEBT     = 8,
   parameter int URGENT_TH    = 6,
   parameter int BANK_W       = 2,
   parameter int ADDR_W       = 13
) (
   input  logic                               ar_clk,
   input  logic                               ar_rst_n,
   input  logic                               init_end,
   input  logic                               ar_en,
   output logic                               ar_req,
   output logic                               ar_urgent,
   output logic                               ar_ack,
   output logic                               ar_end,
   output logic [3:0]                         ar_cmd,
   output logic [BANK_W-1:0]                  ar_bank,
   output logic [ADDR_W-1:0]                  ar_addr,
   output logic [$clog2(MAX_DEBT+1)-1:0]      ar_debt,
   output logic                               ar_overflow
);

   localparam int DEBT_W   = $clog2(MAX_DEBT + 1);
   localparam int WAIT_MAX = (T_RP_CYC > T_RFC_CYC) ? T_RP_CYC : T_RFC_CYC;
   localparam int WAIT_W   = cnt_w(WAIT_MAX - 1);
   localparam int BURST_W  = cnt_w(AR_BURST_MAX);

   localparam logic [DEBT_W-1:0]  D_MAX    = DEBT_W'(MAX_DEBT);
   localparam logic [DEBT_W-1:0]  D_URG    = DEBT_W'(URGENT_TH);
   localparam logic [DEBT_W-1:0]  D_BURST  = DEBT_W'(AR_BURST_MAX);
   localparam logic [BURST_W-1:0] B_MAX    = BURST_W'(AR_BURST_MAX);
   localparam logic [WAIT_W-1:0]  RP_LAST  = WAIT_W'(T_RP_CYC - 1);
   localparam logic [WAIT_W-1:0]  RFC_LAST = WAIT_W'(T_RFC_CYC - 1);

   ar_state_t           state, state_nxt;
   logic [DEBT_W-1:0]   debt, debt_nxt;
   logic [BURST_W-1:0]  burst, issued;
   logic [WAIT_W-1:0]   wait_cnt;
   logic [3:0]          cmd_nxt;
   logic                end_nxt;
   logic                tick;
   logic                in_ar;

   sdram_refi_timer #(
      .T_REFI_CYC (T_REFI_CYC)
   ) u_refi_timer (
      .clk   (ar_clk),
      .rst_n (ar_rst_n),
      .en    (init_end),
      .tick  (tick)
   );

   assign in_ar   = (state == ST_AR);
   assign ar_bank = '1;
   assign ar_addr = '1;
   assign ar_debt = debt;

   // A tick and a refresh in the same cycle cancel, so nothing is lost.
   always_comb begin
      debt_nxt = debt;
      if (!init_end)
         debt_nxt = '0;
      else if (tick && !in_ar) begin
         if (debt != D_MAX)
            debt_nxt = debt + 1'b1;
      end else if (!tick && in_ar) begin
         if (debt != '0)
            debt_nxt = debt - 1'b1;
      end
   end

   always_ff @(posedge ar_clk or negedge ar_rst_n) begin
      if (!ar_rst_n) begin
         debt        <= '0;
         ar_req      <= 1'b0;
         ar_urgent   <= 1'b0;
         ar_overflow <= 1'b0;
      end else begin
         debt      <= debt_nxt;
         ar_req    <= (debt_nxt != '0);
         ar_urgent <= (debt_nxt >= D_URG);
         if (init_end && tick && !in_ar && debt == D_MAX)
            ar_overflow <= 1'b1;
      end
   end

   always_ff @(posedge ar_clk or negedge ar_rst_n) begin
      if (!ar_rst_n)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (init_end && ar_en && debt != '0) state_nxt = ST_PRE;
         ST_PRE:  state_nxt = ST_TRP;
         ST_TRP:  if (wait_cnt == RP_LAST) state_nxt = ST_AR;
         ST_AR:   state_nxt = ST_TRFC;
         ST_TRFC: if (wait_cnt == RFC_LAST)
                     state_nxt = (issued < burst) ? ST_AR : ST_END;
         ST_END:  state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Commands and ar_end are registered, so they lag their state by a cycle.
   always_comb begin
      ar_ack  = (state == ST_IDLE) && (state_nxt == ST_PRE);
      end_nxt = (state == ST_END);
      cmd_nxt = CMD_NOP;
      if (state == ST_PRE)
         cmd_nxt = CMD_PRE;
      else if (state == ST_AR)
         cmd_nxt = CMD_AR;
   end

   always_ff @(posedge ar_clk or negedge ar_rst_n) begin
      if (!ar_rst_n) begin
         ar_cmd   <= CMD_NOP;
         ar_end   <= 1'b0;
         wait_cnt <= '0;
         issued   <= '0;
         burst    <= '0;
      end else begin
         ar_cmd <= cmd_nxt;
         ar_end <= end_nxt;
         if (state_nxt == state && (state == ST_TRP || state == ST_TRFC))
            wait_cnt <= wait_cnt + 1'b1;
         else
            wait_cnt <= '0;
         if (state == ST_IDLE)
            issued <= '0;
         else if (state == ST_AR)
            issued <= issued + 1'b1;
         if (ar_ack)
            burst <= (debt >= D_BURST) ? B_MAX : BURST_W'(debt);
      end
   end

endmodule
